// File: rtl/f1_start_sequencer.sv
// Start-lights sequencer and reaction timer: fills lamps one per tick, holds for a
// random tick count, goes dark, then times the player's response in ticks.
module f1_start_sequencer #(
  parameter int unsigned N_LIGHTS    = 8,
  parameter int unsigned RND_W       = 4,
  parameter int unsigned HOLD_OFFSET = 0,
  parameter int unsigned TIME_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                trigger,
  input  logic                react,
  input  logic [RND_W-1:0]    rnd,
  output logic                lfsr_en,
  output logic [N_LIGHTS-1:0] lights,
  output logic                go,
  output logic                busy,
  output logic [TIME_W-1:0]   react_time,
  output logic                time_valid,
  output logic                jump_start
);

  localparam int unsigned HOLD_MAX = (1 << RND_W) - 1 + HOLD_OFFSET;
  localparam int unsigned HOLD_W   = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);

  localparam logic [N_LIGHTS-1:0] LIGHTS_ALMOST = {1'b0, {(N_LIGHTS-1){1'b1}}};
  localparam logic [N_LIGHTS-1:0] LIGHTS_FULL   = {N_LIGHTS{1'b1}};
  localparam logic [TIME_W-1:0]   TCNT_MAX      = {TIME_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    HOLD   = 3'd2,
    TIMING = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt_c;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [TIME_W-1:0]   tcnt;

  logic [N_LIGHTS-1:0] lights_nxt_c;
  logic [HOLD_W-1:0]   hold_cnt_nxt_c;
  logic [TIME_W-1:0]   tcnt_nxt_c;
  logic [TIME_W-1:0]   tcnt_inc_c;
  logic [TIME_W-1:0]   react_time_nxt_c;
  logic                lfsr_en_nxt_c;
  logic                go_nxt_c;
  logic                time_valid_nxt_c;
  logic                jump_start_nxt_c;
  logic [31:0]         hold_sum_c;
  logic [HOLD_W-1:0]   hold_load_c;

  // Hold count for the round, never below one tick.
  always_comb begin
    hold_sum_c  = 32'(rnd) + 32'(HOLD_OFFSET);
    hold_load_c = (hold_sum_c == 32'd0) ? HOLD_W'(1) : HOLD_W'(hold_sum_c);
  end

  // A tick landing with react still counts toward the measured time.
  always_comb begin
    tcnt_inc_c = tcnt;
    if (tick && (tcnt != TCNT_MAX)) begin
      tcnt_inc_c = tcnt + TIME_W'(1);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_c      = state;
    lights_nxt_c     = lights;
    hold_cnt_nxt_c   = hold_cnt;
    tcnt_nxt_c       = tcnt;
    react_time_nxt_c = react_time;
    lfsr_en_nxt_c    = 1'b0;
    go_nxt_c         = 1'b0;
    time_valid_nxt_c = 1'b0;
    jump_start_nxt_c = jump_start;

    unique case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt_c      = FILL;
          lights_nxt_c     = '0;
          jump_start_nxt_c = 1'b0;
        end
      end

      FILL: begin
        if (react) begin
          state_nxt_c      = DONE;
          lights_nxt_c     = '0;
          jump_start_nxt_c = 1'b1;
        end else if (tick) begin
          lights_nxt_c = {lights[N_LIGHTS-2:0], 1'b1};
          if (lights == LIGHTS_ALMOST) begin
            lights_nxt_c   = LIGHTS_FULL;
            hold_cnt_nxt_c = hold_load_c;
            lfsr_en_nxt_c  = 1'b1;
            state_nxt_c    = HOLD;
          end
        end
      end

      HOLD: begin
        if (react) begin
          state_nxt_c      = DONE;
          lights_nxt_c     = '0;
          jump_start_nxt_c = 1'b1;
        end else if (tick) begin
          hold_cnt_nxt_c = hold_cnt - HOLD_W'(1);
          if (hold_cnt == HOLD_W'(1)) begin
            lights_nxt_c = '0;
            go_nxt_c     = 1'b1;
            tcnt_nxt_c   = '0;
            state_nxt_c  = TIMING;
          end
        end
      end

      TIMING: begin
        tcnt_nxt_c = tcnt_inc_c;
        if (react) begin
          react_time_nxt_c = tcnt_inc_c;
          time_valid_nxt_c = 1'b1;
          state_nxt_c      = DONE;
        end
      end

      DONE: begin
        if (!trigger && !react) begin
          state_nxt_c = IDLE;
        end
      end

      default: begin
        state_nxt_c = IDLE;
      end
    endcase
  end

  // State and registered outputs; busy tracks the next state so it moves with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lights     <= '0;
      hold_cnt   <= '0;
      tcnt       <= '0;
      react_time <= '0;
      lfsr_en    <= 1'b0;
      go         <= 1'b0;
      time_valid <= 1'b0;
      jump_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt_c;
      lights     <= lights_nxt_c;
      hold_cnt   <= hold_cnt_nxt_c;
      tcnt       <= tcnt_nxt_c;
      react_time <= react_time_nxt_c;
      lfsr_en    <= lfsr_en_nxt_c;
      go         <= go_nxt_c;
      time_valid <= time_valid_nxt_c;
      jump_start <= jump_start_nxt_c;
      busy       <= (state_nxt_c != IDLE);
    end
  end

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Directed bench for f1_start_sequencer: a default instance plus a TIME_W=4
// instance sharing the same inputs to observe saturation.
module tb_f1_start_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       trigger;
  logic       react;
  logic [3:0] rnd;

  logic        lfsr_en, go, busy, time_valid, jump_start;
  logic [7:0]  lights;
  logic [15:0] react_time;

  logic        lfsr_en4, go4, busy4, time_valid4, jump_start4;
  logic [7:0]  lights4;
  logic [3:0]  react_time4;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  f1_start_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .react(react), .rnd(rnd),
    .lfsr_en(lfsr_en), .lights(lights), .go(go), .busy(busy),
    .react_time(react_time), .time_valid(time_valid), .jump_start(jump_start)
  );

  f1_start_sequencer #(.TIME_W(4)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .react(react), .rnd(rnd),
    .lfsr_en(lfsr_en4), .lights(lights4), .go(go4), .busy(busy4),
    .react_time(react_time4), .time_valid(time_valid4), .jump_start(jump_start4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
  endtask

  task automatic gap();
    repeat (3) clk1();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick1();
      gap();
    end
  endtask

  initial begin
    logic [7:0] exp_l;
    rst = 1'b1; tick = 1'b0; trigger = 1'b0; react = 1'b0; rnd = 4'hF;
    clk1(); clk1();
    chk("rst_lights", 32'(lights), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_outs", {go, lfsr_en, time_valid, jump_start}, 32'h0);
    chk("rst_rtime", 32'(react_time), 32'h0);
    rst = 1'b0;

    // Test 1: fill with rnd=F, hold of 15 ticks.
    trigger = 1'b1; clk1(); trigger = 1'b0;
    chk("t1_busy_start", 32'(busy), 32'h1);
    chk("t1_lights_start", 32'(lights), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick1();
      exp_l = 8'((16'd1 << (i + 1)) - 16'd1);
      chk("t1_fill_lights", 32'(lights), 32'(exp_l));
      chk("t1_fill_lfsr_en", 32'(lfsr_en), (i == 7) ? 32'h1 : 32'h0);
      gap();
    end
    chk("t1_lfsr_en_one_cycle", 32'(lfsr_en), 32'h0);
    for (int k = 1; k <= 15; k++) begin
      tick1();
      chk("t1_hold_go", 32'(go), (k == 15) ? 32'h1 : 32'h0);
      chk("t1_hold_lights", 32'(lights), (k == 15) ? 32'h0 : 32'hFF);
      chk("t1_hold_busy", 32'(busy), 32'h1);
      gap();
    end
    chk("t1_go_one_cycle", 32'(go), 32'h0);

    // Test 2: react nine ticks after go.
    for (int k = 0; k < 9; k++) begin
      tick1();
      chk("t2_no_tv", 32'(time_valid), 32'h0);
      gap();
    end
    react = 1'b1; clk1();
    chk("t2_tv", 32'(time_valid), 32'h1);
    chk("t2_rtime", 32'(react_time), 32'd9);
    chk("t2_busy_done", 32'(busy), 32'h1);
    clk1();
    chk("t2_tv_one_cycle", 32'(time_valid), 32'h0);
    chk("t2_busy_held", 32'(busy), 32'h1);
    react = 1'b0; clk1();
    chk("t2_busy_release", 32'(busy), 32'h0);
    chk("t2_rtime_kept", 32'(react_time), 32'd9);

    // Test 3: jump start at lights=07.
    trigger = 1'b1; clk1(); trigger = 1'b0;
    ticks(3);
    chk("t3_lights07", 32'(lights), 32'h07);
    react = 1'b1; clk1();
    chk("t3_lights_dark", 32'(lights), 32'h0);
    chk("t3_jump", 32'(jump_start), 32'h1);
    chk("t3_no_pulses", {go, time_valid, lfsr_en}, 32'h0);
    react = 1'b0; clk1();
    chk("t3_idle", 32'(busy), 32'h0);
    chk("t3_jump_sticky", 32'(jump_start), 32'h1);
    trigger = 1'b1; clk1(); trigger = 1'b0;
    chk("t3_jump_cleared", 32'(jump_start), 32'h0);
    chk("t3_busy_again", 32'(busy), 32'h1);

    // Test 4: rnd=0 gives a one-tick hold; react coinciding with a tick counts it.
    rnd = 4'h0;
    ticks(7);
    chk("t4_lights7f", 32'(lights), 32'h7F);
    tick1();
    chk("t4_lights_ff", 32'(lights), 32'hFF);
    chk("t4_lfsr_en", 32'(lfsr_en), 32'h1);
    gap();
    tick1();
    chk("t4_go", 32'(go), 32'h1);
    chk("t4_dark", 32'(lights), 32'h0);
    gap();
    ticks(2);
    react = 1'b1; tick = 1'b1; clk1(); tick = 1'b0;
    chk("t4_tv", 32'(time_valid), 32'h1);
    chk("t4_rtime_tick_incl", 32'(react_time), 32'd3);
    react = 1'b0; clk1();
    chk("t4_idle", 32'(busy), 32'h0);

    // Test 5: reset during HOLD, then during TIMING.
    rnd = 4'hF;
    trigger = 1'b1; clk1(); trigger = 1'b0;
    ticks(8);
    ticks(2);
    chk("t5_in_hold", 32'(lights), 32'hFF);
    rst = 1'b1; clk1(); rst = 1'b0;
    chk("t5h_lights", 32'(lights), 32'h0);
    chk("t5h_busy", 32'(busy), 32'h0);
    chk("t5h_rtime", 32'(react_time), 32'h0);
    chk("t5h_outs", {go, lfsr_en, time_valid, jump_start}, 32'h0);
    clk1();
    chk("t5h_stays_idle", 32'(busy), 32'h0);
    trigger = 1'b1; clk1(); trigger = 1'b0;
    tick1();
    chk("t5_restart_01", 32'(lights), 32'h01);
    gap();
    rnd = 4'h0;
    ticks(6);
    tick1();
    chk("t5_full", 32'(lights), 32'hFF);
    gap();
    tick1();
    chk("t5_go", 32'(go), 32'h1);
    gap();
    ticks(2);
    rst = 1'b1; clk1(); rst = 1'b0;
    chk("t5t_busy", 32'(busy), 32'h0);
    chk("t5t_outs", {go, lfsr_en, time_valid, jump_start}, 32'h0);
    chk("t5t_lights", 32'(lights), 32'h0);
    trigger = 1'b1; clk1(); trigger = 1'b0;
    tick1();
    chk("t5t_restart_01", 32'(lights), 32'h01);
    gap();

    // Test 6: 20 ticks without react saturates the 4-bit timer.
    ticks(6);
    tick1();
    chk("t6_full", 32'(lights), 32'hFF);
    gap();
    tick1();
    chk("t6_go4", 32'(go4), 32'h1);
    gap();
    ticks(20);
    react = 1'b1; trigger = 1'b1; clk1();
    chk("t6_tv4", 32'(time_valid4), 32'h1);
    chk("t6_rtime4_sat", 32'(react_time4), 32'hF);
    chk("t6_rtime16", 32'(react_time), 32'd20);
    react = 1'b0;
    repeat (3) clk1();
    chk("t6_done_held4", 32'(busy4), 32'h1);
    chk("t6_done_held", 32'(busy), 32'h1);
    chk("t6_dark", 32'(lights4), 32'h0);
    trigger = 1'b0; clk1();
    chk("t6_release4", 32'(busy4), 32'h0);
    clk1();
    chk("t6_stay_idle", 32'(busy), 32'h0);
    chk("t6_no_restart_lights", 32'(lights), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/f1_start_sequencer.md
Name: f1_start_sequencer

Overview:
- Start-lights sequencer and reaction timer for the lights lab.
- Consumes the 4-bit pseudo-random word from the upstream LFSR stage and drives that stage's enable for one cycle per round, so each round's hold time differs.
- Paced by an external single-cycle tick strobe from the clock-tick prescaler.
- Lights fill one per tick, hold for a random number of ticks, go dark, then the block times the player's response in ticks.

Parameters:
- N_LIGHTS, 8, number of lamps; width of lights output.
- RND_W, 4, width of random input.
- HOLD_OFFSET, 0, constant ticks added to the random hold count.
- TIME_W, 16, width of reaction-time counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pacing strobe; all timing is counted in ticks.
- trigger  in  1  start request, level-sampled.
- react  in  1  player response, level-sampled.
- rnd  in  RND_W  random value from the LFSR stage.
- lfsr_en  out  1  one-cycle pulse advancing the LFSR.
- lights  out  N_LIGHTS  lamp drive, bit 0 lit first.
- go  out  1  one-cycle pulse when the lights go out.
- busy  out  1  high in any state other than IDLE.
- react_time  out  TIME_W  last measured reaction time in ticks.
- time_valid  out  1  one-cycle pulse when react_time updates.
- jump_start  out  1  sticky fault flag.

Behaviour:
- All outputs are registered. "Tick edge" means a posedge with tick=1.
- States and transitions:
  - IDLE → FILL: on trigger=1. lights=0, jump_start cleared.
  - FILL: each tick edge does lights <= {lights[N-2:0],1'b1}.
    - On the tick edge where lights==all-but-MSB, lights becomes all ones.
    - On that same edge: hold_cnt <= rnd+HOLD_OFFSET (clamped to a minimum of 1), lfsr_en=1 for that one cycle, → HOLD.
  - HOLD: each tick edge decrements hold_cnt.
    - On the tick edge with hold_cnt==1: lights <= 0, go=1 for one cycle, tcnt <= 0, → TIMING.
  - TIMING: each tick edge increments tcnt, saturating at all ones.
    - On the first cycle with react=1: react_time <= tcnt, time_valid=1 for one cycle, → DONE.
    - tick and react in the same cycle: tcnt includes that tick.
  - DONE → IDLE: when trigger=0 and react=0. Re-arming requires release of both inputs.
  - Jump start (react=1 in FILL or HOLD): lights <= 0, jump_start <= 1, no go, no time_valid, no lfsr_en, → DONE. jump_start holds until the next IDLE→FILL transition.
- Ignored inputs:
  - trigger is ignored outside IDLE.
  - rnd is sampled only at the FILL→HOLD edge.
  - tick is ignored in IDLE and DONE.
- Cycle counts:
  - Exactly N_LIGHTS tick edges from the start of FILL to full lights.
  - Exactly hold_cnt further tick edges to go.
- Reset: rst=1 at any posedge forces IDLE, mid-round included, and clears all of:
  - lights, lfsr_en, go, busy, time_valid, jump_start, react_time, hold_cnt, tcnt.
  - Reset has priority over every other input.
- busy is registered and follows the state register in the same cycle as the state change.

Test Plan:
1. rst, then trigger=1 for 1 cycle, tick every 4 clks, rnd=4'hF → lights shows 01,03,07…FF on successive ticks; lfsr_en pulses once, on the FF edge; go pulses 15 ticks later; busy=1 throughout.
2. After go, react=1 asserted 9 ticks later → time_valid pulse, react_time=9. Release both inputs → busy=0 one cycle later.
3. react=1 while lights=8'h07 → lights=0, jump_start=1, no go/time_valid/lfsr_en. The next trigger clears jump_start.
4. rnd=0, HOLD_OFFSET=0 → hold is 1 tick; go occurs on the tick after lights=FF.
5. rst pulsed during HOLD, and separately during TIMING → all outputs 0 the next cycle; a fresh trigger restarts from lights=01.
6. TIME_W=4, no react for 20 ticks, then react → react_time=4'hF (saturated). Holding trigger=1 in DONE does not restart until released.
